// File: rtl/arb_pkg.sv
// Shared types and constants for the request arbiter.
package arb_pkg;

    localparam int         IDX_W    = 8;
    localparam logic [7:0] IDX_NONE = 8'hF0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/req_rr_arbiter_prio_enc_rot.sv
// Rotating MSB-first priority encoder: scans descending from ptr-1, wrapping, ptr last.
// Fixed mode behaves as a scan with ptr=0, i.e. plain highest-index-wins.
module prio_enc_rot
    import arb_pkg::*;
#(
    parameter int N_REQ = 16
) (
    input  logic [N_REQ-1:0] vec,
    input  logic [3:0]       ptr,
    input  logic             rr_mode,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int start;
        int j;
        any   = 1'b0;
        idx   = IDX_NONE;
        start = rr_mode ? int'(ptr) : 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = start - k;
            if (j < 0) j = j + N_REQ;
            if (!any && vec[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/req_rr_arbiter.sv
// Fixed-priority / round-robin arbiter with grant hold, abandon detect and hold timeout.
//   state | meaning
//   IDLE  | no grant held; arbitrate any pending request at the next edge
//   GRANT | grant held until done, abandon (req[gnt_idx]=0) or hold timeout
module req_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [3:0] PTR_RST   = 4'(N_REQ - 1);

    state_t             state, state_nxt;
    logic [7:0]         hold_cnt, hold_nxt;
    logic [3:0]         ptr, ptr_nxt;
    logic [N_REQ-1:0]   gnt_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               valid_nxt;
    logic               timeout_nxt;
    logic               win_any;
    logic [IDX_W-1:0]   win_idx;
    logic               cur_req;
    logic               hold_done;

    prio_enc_rot #(.N_REQ(N_REQ)) u_enc (
        .vec     (req),
        .ptr     (ptr),
        .rr_mode (rr_mode),
        .any     (win_any),
        .idx     (win_idx)
    );

    // gnt is one-hot, so this is req[gnt_idx] without a variable index
    assign cur_req   = |(req & gnt);
    assign hold_done = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    state_nxt = GRANT;
                    hold_nxt  = 8'd0;
                    gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx[3:0];
                    idx_nxt   = win_idx;
                    valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (done || !cur_req || hold_done) begin
                    // done and abandon outrank timeout, so the pulse is only for a pure timeout
                    timeout_nxt = !done && cur_req && hold_done;
                    state_nxt   = IDLE;
                    ptr_nxt     = gnt_idx[3:0];
                    gnt_nxt     = '0;
                    idx_nxt     = IDX_NONE;
                    valid_nxt   = 1'b0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= 8'd0;
            ptr       <= PTR_RST;
            gnt       <= '0;
            gnt_idx   <= IDX_NONE;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Directed and randomized check of req_rr_arbiter against a cycle-level behavioural model.
module tb_req_rr_arbiter;

    localparam int N   = 16;
    localparam int MH  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          rr_mode;
    logic          done;
    logic [N-1:0]  gnt;
    logic [7:0]    gnt_idx;
    logic          gnt_valid;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;

    // reference state
    logic          m_valid;
    int            m_idx;
    int            m_ptr;
    int            m_cnt;
    logic          m_to;

    req_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Scan order: ptr-1 down to 0, then N-1 down to ptr; fixed mode is a plain top-down scan.
    function automatic int winner(input logic [N-1:0] r, input int p, input logic rr);
        int order[$];
        int s;
        s = rr ? p : N;
        for (int i = s - 1; i >= 0; i--) order.push_back(i);
        for (int i = N - 1; i >= s; i--) order.push_back(i);
        foreach (order[k]) if (r[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic model_step();
        logic abandon;
        if (rst) begin
            m_valid = 1'b0; m_idx = -1; m_cnt = 0; m_to = 1'b0; m_ptr = N - 1;
        end else if (!m_valid) begin
            m_to = 1'b0;
            if (req != '0) begin
                m_idx = winner(req, m_ptr, rr_mode);
                m_valid = 1'b1;
                m_cnt = 0;
            end
        end else begin
            abandon = !req[m_idx];
            m_to = 1'b0;
            if (done || abandon || m_cnt == MH - 1) begin
                m_to = !done && !abandon;
                m_ptr = m_idx;
                m_valid = 1'b0;
                m_idx = -1;
            end else if (m_cnt < MH) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0] e_gnt;
        logic [7:0]   e_idx;
        e_gnt = m_valid ? (N'(1) << m_idx) : '0;
        e_idx = m_valid ? 8'(m_idx) : 8'hF0;
        vectors += 4;
        assert (gnt === e_gnt) else begin
            miscompares++; $error("FAIL %s gnt got %h exp %h", tag, gnt, e_gnt);
        end
        assert (gnt_idx === e_idx) else begin
            miscompares++; $error("FAIL %s gnt_idx got %h exp %h", tag, gnt_idx, e_idx);
        end
        assert (gnt_valid === m_valid) else begin
            miscompares++; $error("FAIL %s gnt_valid got %b exp %b", tag, gnt_valid, m_valid);
        end
        assert (timeout === m_to) else begin
            miscompares++; $error("FAIL %s timeout got %b exp %b", tag, timeout, m_to);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic expect_idx(input string tag, input logic [7:0] exp);
        vectors++;
        assert (gnt_idx === exp) else begin
            miscompares++; $error("FAIL %s gnt_idx got %h exp %h", tag, gnt_idx, exp);
        end
    endtask

    initial begin
        logic [7:0] rr_order [5];
        rr_order = '{8'd15, 8'd10, 8'd5, 8'd0, 8'd15};
        rst = 1'b1; req = '0; rr_mode = 1'b0; done = 1'b0;
        m_valid = 1'b0; m_idx = -1; m_ptr = N - 1; m_cnt = 0; m_to = 1'b0;

        // reset, then idle with no requests
        cyc("rst0"); cyc("rst1");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc("idle");

        // fixed priority
        req = 16'h8421;
        cyc("fix_g");
        expect_idx("fix_first", 8'd15);
        done = 1'b1; cyc("fix_rel");
        done = 1'b0; cyc("fix_g2");
        expect_idx("fix_second", 8'd15);
        done = 1'b1; cyc("fix_rel2");
        done = 1'b0; req = '0; cyc("fix_idle");

        // round robin: park ptr at 0 so the full rotation starts at 15
        rr_mode = 1'b1; req = 16'h0001;
        cyc("rr_park");
        done = 1'b1; cyc("rr_park_rel");
        done = 1'b0; req = 16'h8421;
        for (int g = 0; g < 5; g++) begin
            cyc("rr_g");
            expect_idx("rr_order", rr_order[g]);
            done = 1'b1; cyc("rr_rel");
            done = 1'b0;
        end
        req = '0; cyc("rr_idle");

        // hold timeout: grant lasts MH cycles, pulse on release only
        rr_mode = 1'b0; req = 16'h0010;
        for (int i = 0; i < 2 * MH + 3; i++) cyc("tmo");
        req = '0; cyc("tmo_idle"); cyc("tmo_idle2");

        // done + abandon + limit in one cycle: no timeout; rr_mode toggle mid-grant
        req = 16'h0008;
        cyc("pri_g");
        rr_mode = 1'b1; req = 16'h8008; cyc("pri_h1");
        cyc("pri_h2");
        rr_mode = 1'b0; cyc("pri_h3");
        expect_idx("pri_hold", 8'd3);
        done = 1'b1; req = '0; cyc("pri_rel");
        vectors++;
        assert (timeout === 1'b0) else begin
            miscompares++; $error("FAIL pri_timeout got %b exp 0", timeout);
        end
        done = 1'b0; cyc("pri_idle");

        // reset mid-grant, then RR from the reset pointer
        rr_mode = 1'b1; req = 16'h0080;
        cyc("rg_g"); cyc("rg_h");
        expect_idx("rg_hold", 8'd7);
        rst = 1'b1; cyc("rg_rst");
        expect_idx("rg_drop", 8'hF0);
        rst = 1'b0; req = 16'h0081; cyc("rg_after");
        expect_idx("rg_ptr15", 8'd7);
        req = '0; done = 1'b1; cyc("rg_rel");
        done = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            req     = N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) req = '0;
            done    = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            rst     = ($urandom_range(0, 79) == 0);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
